cfa_pre_equ_scheduler: RTL and testbench

Raster-scan sequencer for the diagonal-interpolation datapath (equations 24-27), which computes missing B at R sites and missing R at B sites from the four diagonal G/RB neighbours.
- Walks the interior of a Bayer frame and skips G sites.
- Requests each 3x3 diagonal window from the window/line-buffer block via a req/ack handshake.
- Pulses the datapath enable.
- Tags each result with its coordinates and site type after the fixed datapath latency.
- Sits between the line-buffer window generator and the pre-equalisation datapath.

---
 rtl/cfa_pre_equ_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_cfa_pre_equ_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfa_pre_equ_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cfa_pre_equ_scheduler: raster sequencer issuing R/B sites of a Bayer     |
// | frame to the diagonal-interpolation datapath, tagging results.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cfa_pre_equ_scheduler #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 10,
    parameter int LAT   = 2,
    parameter int BAYER = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          win_req,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    input  logic          win_ack,
    output logic          eq_en,
    output logic          eq_site,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_site
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SCAN     = 2'd1;
    localparam logic [1:0] c_WAIT_ACK = 2'd2;
    localparam logic [1:0] c_DRAIN    = 2'd3;

    // {row parity, col parity} of the R site; the B site is its diagonal opposite
    localparam logic [1:0]    c_r_pos    = 2'(BAYER);
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [CW-1:0] c_row_last = CW'(IMG_H - 2);
    localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 2);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [CW-1:0] tag_row_q, tag_row_d, tag_col_q, tag_col_d;
    logic          site_q, site_d;
    logic          eq_en_q, eq_en_d;
    logic          done_q, done_d;

    logic [LAT-1:0] pv_q;
    logic [LAT-1:0] psite_q;
    logic [CW-1:0]  prow_q [LAT];
    logic [CW-1:0]  pcol_q [LAT];

    logic w_is_r, w_is_b, w_last, w_adv, w_pend;

    assign w_is_r = ({row_q[0], col_q[0]} == c_r_pos);
    assign w_is_b = ({row_q[0], col_q[0]} == ~c_r_pos);
    assign w_last = (row_q == c_row_last) && (col_q == c_col_last);

    // Pending work excludes the output stage, so done lands right after the last result
    always_comb begin
        w_pend = eq_en_q;
        for (int i = 0; i < LAT - 1; i++) begin
            w_pend = w_pend | pv_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= c_IDLE;
            row_q     <= c_one;
            col_q     <= c_one;
            tag_row_q <= '0;
            tag_col_q <= '0;
            site_q    <= 1'b0;
            eq_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tag_row_q <= tag_row_d;
            tag_col_q <= tag_col_d;
            site_q    <= site_d;
            eq_en_q   <= eq_en_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tag_row_d = tag_row_q;
        tag_col_d = tag_col_q;
        site_d    = site_q;
        eq_en_d   = 1'b0;
        done_d    = 1'b0;
        w_adv     = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_SCAN;
                    row_d   = c_one;
                    col_d   = c_one;
                end
            end
            c_SCAN: begin
                if (!(w_is_r || w_is_b)) begin
                    w_adv = 1'b1;
                end else if (out_ready) begin
                    state_d = c_WAIT_ACK;
                    site_d  = w_is_b;
                end
            end
            c_WAIT_ACK: begin
                if (win_ack) begin
                    state_d   = c_SCAN;
                    eq_en_d   = 1'b1;
                    tag_row_d = row_q;
                    tag_col_d = col_q;
                    w_adv     = 1'b1;
                end
            end
            c_DRAIN: begin
                if (!w_pend) begin
                    state_d = c_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
        if (w_adv) begin
            if (w_last) begin
                state_d = c_DRAIN;
            end else if (col_q == c_col_last) begin
                col_d = c_one;
                row_d = row_q + c_one;
            end else begin
                col_d = col_q + c_one;
            end
        end
    end

    always_comb begin
        busy    = (state_q != c_IDLE);
        win_req = (state_q == c_WAIT_ACK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pv_q    <= '0;
            psite_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                prow_q[i] <= '0;
                pcol_q[i] <= '0;
            end
        end else begin
            pv_q[0]    <= eq_en_q;
            psite_q[0] <= site_q;
            prow_q[0]  <= tag_row_q;
            pcol_q[0]  <= tag_col_q;
            for (int i = 1; i < LAT; i++) begin
                pv_q[i]    <= pv_q[i-1];
                psite_q[i] <= psite_q[i-1];
                prow_q[i]  <= prow_q[i-1];
                pcol_q[i]  <= pcol_q[i-1];
            end
        end
    end

    assign done      = done_q;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign eq_en     = eq_en_q;
    assign eq_site   = site_q;
    assign out_valid = pv_q[LAT-1];
    assign out_row   = prow_q[LAT-1];
    assign out_col   = pcol_q[LAT-1];
    assign out_site  = psite_q[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_cfa_pre_equ_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cfa_pre_equ_scheduler: 6x5 frame bench with a frame-level model.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cfa_pre_equ_scheduler;

    localparam int W   = 6;
    localparam int H   = 5;
    localparam int CW  = 10;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, win_ack, out_ready;
    logic          busy, done, win_req, eq_en, eq_site, out_valid, out_site;
    logic [CW-1:0] win_row, win_col, out_row, out_col;

    logic          start3;
    logic          busy3, done3, req3, en3, site3, ov3, os3;
    logic [CW-1:0] row3, col3, or3, oc3;

    cfa_pre_equ_scheduler #(.IMG_W(W), .IMG_H(H), .CW(CW), .LAT(LAT), .BAYER(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .win_req(win_req), .win_row(win_row), .win_col(win_col), .win_ack(win_ack),
        .eq_en(eq_en), .eq_site(eq_site), .out_ready(out_ready),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_site(out_site)
    );

    cfa_pre_equ_scheduler #(.IMG_W(W), .IMG_H(H), .CW(CW), .LAT(LAT), .BAYER(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .win_req(req3), .win_row(row3), .win_col(col3), .win_ack(req3),
        .eq_en(en3), .eq_site(site3), .out_ready(1'b1),
        .out_valid(ov3), .out_row(or3), .out_col(oc3), .out_site(os3)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Frame model: every interior position in raster order, keeping only R/B sites
    logic [20:0] mdl[$];
    function automatic void model_frame(input int bayer);
        int rr, rc;
        case (bayer)
            0: begin rr = 0; rc = 0; end
            1: begin rr = 0; rc = 1; end
            2: begin rr = 1; rc = 0; end
            default: begin rr = 1; rc = 1; end
        endcase
        mdl.delete();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                if ((r % 2 == rr) && (c % 2 == rc))
                    mdl.push_back({10'(r), 10'(c), 1'b0});
                else if ((r % 2 != rr) && (c % 2 != rc))
                    mdl.push_back({10'(r), 10'(c), 1'b1});
            end
        end
    endfunction

    // Stimulus driver: start pulses, out_ready pattern, window responder
    int go_req = 0, go_seen = 0, go3_req = 0, go3_seen = 0;
    bit noise_start = 0, ack_noise = 0, rrand = 0, block22 = 0;
    int dmode = 0, rcnt = 0, cur_delay = 0, req_idx = 0, blk_cnt = 0;
    int dq[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (go_req != go_seen) begin
                start   = 1'b1;
                go_seen = go_req;
                req_idx = 0;
            end else begin
                start = noise_start && busy && ($urandom_range(0, 3) == 0);
            end
            start3   = (go3_req != go3_seen);
            go3_seen = go3_req;
            out_ready = rrand ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!block22) blk_cnt = 0;
            else if (busy && !win_req && win_row == 2 && win_col == 2 && blk_cnt < 4) begin
                out_ready = 1'b0;
                blk_cnt++;
            end
            if (win_req) begin
                if (rcnt == 0) begin
                    case (dmode)
                        1: cur_delay = (req_idx == 2) ? 5 : 0;
                        2: cur_delay = int'($urandom_range(0, 3));
                        3: cur_delay = (win_row == 3 && win_col == 1) ? 100000 : 0;
                        default: cur_delay = 0;
                    endcase
                    dq.push_back(cur_delay);
                    req_idx++;
                end
                win_ack = (rcnt == cur_delay);
                rcnt++;
            end else begin
                rcnt    = 0;
                win_ack = ack_noise && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: issue order, handshake shape, eq_en timing and result latency
    typedef struct { int due; logic [20:0] tag; } ent_t;
    ent_t        pend[$];
    logic [20:0] exp_iss[$];
    logic [20:0] q3[$];
    bit          mon_en = 0;
    logic        p_req = 1'b0, p_ready = 1'b0;
    int          cyc = 0, req_len = 0, ack_cyc = -10;
    int          res_cnt = 0, done_cnt = 0, res3 = 0, done3_cnt = 0;
    logic [20:0] req_pos = '0, ack_tag = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        logic        exp_v, exp_eq;
        logic [20:0] cur;
        ent_t        e;
        cur = {win_row, win_col, eq_site};
        if (!mon_en) begin
            dq.delete();
            pend.delete();
            ack_cyc = -10;
        end else begin
            if (win_req && !p_req) begin
                chk("req_ready", p_ready, 1);
                req_len = 1;
                req_pos = cur;
            end else if (win_req) begin
                chk("req_hold", cur, req_pos);
                req_len++;
            end
            if (!win_req && p_req && dq.size() > 0) chk("req_len", req_len, dq.pop_front() + 1);
            if (win_req && win_ack) begin
                if (exp_iss.size() == 0) chk("extra_issue", 1, 0);
                else chk("issue_tag", cur, exp_iss.pop_front());
                ack_cyc = cyc;
                ack_tag = cur;
            end
            exp_eq = (cyc == ack_cyc + 1);
            if (eq_en || exp_eq) begin
                chk("eq_en", eq_en, exp_eq);
                if (eq_en) begin
                    chk("eq_site", eq_site, ack_tag[0]);
                    e.due = cyc + LAT;
                    e.tag = ack_tag;
                    pend.push_back(e);
                end
            end
            exp_v = (pend.size() > 0) ? (pend[0].due == cyc) : 1'b0;
            if (out_valid || exp_v) begin
                chk("out_valid", out_valid, exp_v);
                if (out_valid && exp_v) begin
                    chk("out_tag", {out_row, out_col, out_site}, pend[0].tag);
                    res_cnt++;
                end
                if (exp_v) void'(pend.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("done_busy", busy, 0);
                chk("done_drained", exp_iss.size() + pend.size(), 0);
            end
        end
        p_req   = win_req;
        p_ready = out_ready;
        if (ov3) begin
            if (q3.size() > 0) chk("b3_out_tag", {or3, oc3, os3}, q3.pop_front());
            else chk("b3_extra_out", 1, 0);
            res3++;
        end
        if (done3) done3_cnt++;
    end

    task automatic chk_rst();
        chk("rst_state", {busy, done, win_req, eq_en, out_valid, eq_site, out_site,
                          win_row, win_col, out_row, out_col}, {7'b0, 10'd1, 10'd1, 20'd0});
        chk("b3_rst_state", {busy3, done3, req3, en3, ov3, site3, os3, row3, col3, or3, oc3},
            {7'b0, 10'd1, 10'd1, 20'd0});
    endtask

    task automatic run_frame(input int mode, input bit rr, input bit noise, input bit blk);
        int t;
        dmode = mode; rrand = rr; block22 = blk; ack_noise = noise;
        model_frame(0);
        exp_iss  = mdl;
        res_cnt  = 0;
        done_cnt = 0;
        if (noise) begin
            repeat (6) @(negedge clk);
            chk("idle_ack_ignored", {busy, win_req, eq_en, out_valid}, 4'b0);
        end
        @(negedge clk);
        go_req++;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        noise_start = noise;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done_seen", done_cnt > 0, 1);
        noise_start = 0;
        repeat (LAT + 4) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("result_count", res_cnt, mdl.size());
        chk("busy_idle", busy, 0);
        dmode = 0; rrand = 0; block22 = 0; ack_noise = 0;
    endtask

    task automatic run_frame3();
        int t;
        model_frame(3);
        q3 = mdl;
        res3 = 0;
        done3_cnt = 0;
        @(negedge clk);
        go3_req++;
        t = 0;
        while (done3_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("b3_done_once", done3_cnt, 1);
        chk("b3_result_count", res3, mdl.size());
        chk("b3_busy_idle", busy3, 0);
    endtask

    task automatic run_reset_mid();
        int t, stray;
        dmode = 3;
        model_frame(0);
        exp_iss = mdl;
        @(negedge clk);
        go_req++;
        t = 0;
        while (!(win_req && win_row == 3 && win_col == 1) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_wait_3_1", {win_req, win_row, win_col}, {1'b1, 10'd3, 10'd1});
        @(posedge clk);
        #2 rst = 1'b0;
        mon_en = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_rst();
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || eq_en || win_req || busy) stray++;
        end
        chk("post_rst_quiet", stray, 0);
        exp_iss.delete();
        dmode  = 0;
        mon_en = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; start3 = 1'b0; win_ack = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst();
        @(posedge clk);
        #2 rst = 1'b1;
        mon_en = 1;
        run_frame(0, 0, 0, 0);
        run_frame3();
        run_frame(1, 0, 0, 1);
        run_reset_mid();
        run_frame(0, 0, 1, 0);
        repeat (4) run_frame(2, 1, 1, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
